// File: rtl/ext_irq_ctrl_if.sv
// Signal bundle between ext_irq_ctrl and its surroundings: raw device lines, mask
// register access, status readback and the ExtIRQ/ExtIAck processor handshake.
interface ext_irq_ctrl_if #(
  parameter int N_CH = 4,
  parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0] irq_in;
  logic            mask_we;
  logic [N_CH-1:0] mask_wdata;
  logic [N_CH-1:0] mask_q;
  logic [N_CH-1:0] pending_q;
  logic            ExtIRQ;
  logic            ExtIAck;
  logic [ID_W-1:0] irq_id;

  modport master (
    output irq_in, mask_we, mask_wdata, ExtIAck,
    input  mask_q, pending_q, ExtIRQ, irq_id
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, ExtIAck,
    output mask_q, pending_q, ExtIRQ, irq_id
  );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises N_CH device lines, latches edge/level
// pending bits, masks and arbitrates them onto ExtIRQ/ExtIAck. Optional macro
// EXT_IRQ_ROUND_ROBIN_EN selects round-robin instead of fixed-priority arbitration.
module ext_irq_ctrl #(
  parameter int              N_CH        = 4,
  parameter int              ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter logic [N_CH-1:0] EDGE_MODE   = {N_CH{1'b1}},
  parameter int              SYNC_STAGES = 2
) (
  input logic           CLOCK_50,
  input logic           reset,
  ext_irq_ctrl_if.slave bus
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] sync_q [SS];
  logic [N_CH-1:0] s, s_d;
  logic [N_CH-1:0] rise, clr;
  logic [N_CH-1:0] edge_pend_q;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] mask_r;
  logic [N_CH-1:0] elig_q;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] winner;
  logic            ack_take;

  function automatic int lowest(input logic [N_CH-1:0] v);
    int r;
    r = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (v[k]) r = k;
    end
    return r;
  endfunction

  // Input synchroniser chain plus one delay stage for edge detection
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SS; i++) sync_q[i] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SS; i++) sync_q[i] <= sync_q[i-1];
      s_d <= s;
    end
  end

  assign s    = sync_q[SS-1];
  assign rise = s & ~s_d & EDGE_MODE;
  assign clr  = ack_take ? (N_CH'(1) << id_q) : '0;

  // Set is ORed after the clear so an edge landing on the ack cycle survives
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      edge_pend_q <= '0;
    end else begin
      edge_pend_q <= ((edge_pend_q & ~clr) | rise) & EDGE_MODE;
    end
  end

  assign pending = (edge_pend_q & EDGE_MODE) | (s & ~EDGE_MODE);

  // Mask register and registered eligibility vector feeding the arbiter
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mask_r <= '0;
      elig_q <= '0;
    end else begin
      if (bus.mask_we) mask_r <= bus.mask_wdata;
      elig_q <= pending & mask_r;
    end
  end

`ifdef EXT_IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_q;

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] v,
                                              input logic [ID_W-1:0] start);
    logic [N_CH-1:0] rot;
    int              sum;
    rot = (v >> start) | (v << (N_CH - int'(start)));
    sum = lowest(rot) + int'(start);
    if (sum >= N_CH) sum = sum - N_CH;
    return ID_W'(sum);
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
    end else if (ack_take) begin
      rr_q <= (id_q == ID_W'(N_CH - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign winner = rr_pick(elig_q, rr_q);
`else
  assign winner = ID_W'(lowest(elig_q));
`endif

  // Handshake FSM
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig_q) begin
          state_d = REQ;
          id_d    = winner;
        end
      end
      REQ: begin
        if (bus.ExtIAck) begin
          state_d  = DROP;
          ack_take = 1'b1;
        end
      end
      DROP: begin
        if (!bus.ExtIAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mask_q    = mask_r;
  assign bus.pending_q = pending;
  assign bus.ExtIRQ    = (state_q == REQ);
  assign bus.irq_id    = id_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: directed handshake scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the controller rules.
module tb_ext_irq_ctrl;
  localparam int              N    = 4;
  localparam int              IDW  = 2;
  localparam int              SS   = 2;
  localparam logic [N-1:0]    EDGE = 4'b1101;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  int   first_id;

  ext_irq_ctrl_if #(.N_CH(N), .ID_W(IDW)) bus ();

  ext_irq_ctrl #(
    .N_CH(N), .ID_W(IDW), .EDGE_MODE(EDGE), .SYNC_STAGES(SS)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: sample history, latched edge bits, eligibility seen by the arbiter
  logic [N-1:0] hist [0:SS];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_elig = '0;
  logic         m_req  = 1'b0;
  logic         m_drop = 1'b0;
  int           m_id   = 0;
  int           m_ptr  = 0;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] m_pending();
    return (m_pend & EDGE) | (hist[SS-1] & ~EDGE);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= SS; i++) hist[i] = '0;
      m_pend = '0; m_mask = '0; m_elig = '0;
      m_req = 1'b0; m_drop = 1'b0; m_id = 0; m_ptr = 0;
    end else begin
      logic [N-1:0] rise, pend_now, elig_prev;
      logic         ack_now;
      rise      = hist[SS-1] & ~hist[SS] & EDGE;
      pend_now  = m_pending();
      elig_prev = m_elig;
      ack_now   = m_req && bus.ExtIAck;
      if (ack_now && EDGE[m_id]) m_pend[m_id] = 1'b0;
      m_pend = m_pend | rise;
      m_elig = pend_now & m_mask;
      if (bus.mask_we) m_mask = bus.mask_wdata;
      if (m_req) begin
        if (bus.ExtIAck) begin
          m_req  = 1'b0;
          m_drop = 1'b1;
`ifdef EXT_IRQ_ROUND_ROBIN_EN
          m_ptr = (m_id + 1) % N;
`endif
        end
      end else if (m_drop) begin
        if (!bus.ExtIAck) m_drop = 1'b0;
      end else if (elig_prev != 0) begin
        m_req = 1'b1;
        m_id  = pick(elig_prev, m_ptr);
      end
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.irq_in;
    end
  end

  always @(negedge clk) begin
    if (mon_on && reset) begin
      chk("irq", 32'(bus.ExtIRQ), 32'(m_req));
      if (m_req) chk("id", 32'(bus.irq_id), 32'(m_id));
      chk("mask", 32'(bus.mask_q), 32'(m_mask));
      chk("pend", 32'(bus.pending_q), 32'(m_pending()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mask(input logic [N-1:0] v);
    bus.mask_we = 1'b1; bus.mask_wdata = v;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    bus.irq_in = bus.irq_in | v;
    tick();
    bus.irq_in = bus.irq_in & ~v;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!bus.ExtIRQ && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.ExtIRQ), 32'd1);
  endtask

  task automatic ack_cycle();
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.ExtIAck = 1'b0;
    #1;
    chk("rst_irq",  32'(bus.ExtIRQ),    32'd0);
    chk("rst_id",   32'(bus.irq_id),    32'd0);
    chk("rst_mask", 32'(bus.mask_q),    32'd0);
    chk("rst_pend", 32'(bus.pending_q), 32'd0);
    tick(3);
    reset  = 1'b1;
    mon_on = 1'b1;
    tick();

    // Single edge channel, latency and ack
    set_mask(4'b0001);
    pulse(4'b0001);
    tick(3);
    chk("t1_early", 32'(bus.ExtIRQ), 32'd0);
    tick();
    chk("t1_irq", 32'(bus.ExtIRQ), 32'd1);
    chk("t1_id",  32'(bus.irq_id), 32'd0);
    bus.ExtIAck = 1'b1;
    tick();
    chk("t1_pend", 32'(bus.pending_q), 32'd0);
    chk("t1_drop", 32'(bus.ExtIRQ),    32'd0);
    bus.ExtIAck = 1'b0;
    tick();

    // Masked pending, then unmask
    set_mask(4'b0000);
    pulse(4'b0100);
    tick(3);
    chk("t3_pend",   32'(bus.pending_q), 32'h4);
    chk("t3_masked", 32'(bus.ExtIRQ),    32'd0);
    set_mask(4'b0100);
    chk("t3_w0", 32'(bus.ExtIRQ), 32'd0);
    tick();
    chk("t3_w1", 32'(bus.ExtIRQ), 32'd0);
    tick();
    chk("t3_irq", 32'(bus.ExtIRQ), 32'd1);
    chk("t3_id",  32'(bus.irq_id), 32'd2);
    ack_cycle();

    // Two channels together: level ch1 then edge ch3
    set_mask(4'b1111);
    pulse(4'b1010);
    tick(3);
    chk("t2_irq", 32'(bus.ExtIRQ), 32'd1);
    chk("t2_id",  32'(bus.irq_id), 32'd1);
    ack_cycle();
    tick();
    chk("t2_irq2", 32'(bus.ExtIRQ), 32'd1);
    chk("t2_id2",  32'(bus.irq_id), 32'd3);
    bus.ExtIAck = 1'b1;
    tick();
    chk("t2_pend", 32'(bus.pending_q), 32'd0);
    bus.ExtIAck = 1'b0;
    tick();

    // Level channel held high re-requests; no retraction after drop
    bus.irq_in[1] = 1'b1;
    wait_irq("t4_irq");
    chk("t4_id", 32'(bus.irq_id), 32'd1);
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    tick();
    chk("t4_gap", 32'(bus.ExtIRQ), 32'd0);
    tick();
    chk("t4_re",   32'(bus.ExtIRQ), 32'd1);
    chk("t4_reid", 32'(bus.irq_id), 32'd1);
    bus.irq_in[1] = 1'b0;
    tick(4);
    chk("t4_hold", 32'(bus.ExtIRQ), 32'd1);
    ack_cycle();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_quiet", 32'(bus.ExtIRQ), 32'd0);
    end

    // Ack held high stalls in DROP with another channel pending
    pulse(4'b0101);
    wait_irq("t5_irq");
    chk("t5_id", 32'(bus.irq_id), 32'(m_id));
    first_id = int'(bus.irq_id);
    bus.ExtIAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_stall", 32'(bus.ExtIRQ), 32'd0);
    end
    bus.ExtIAck = 1'b0;
    tick();
    chk("t5_gap", 32'(bus.ExtIRQ), 32'd0);
    tick();
    chk("t5_next",  32'(bus.ExtIRQ), 32'd1);
    chk("t5_nextid", 32'(bus.irq_id), (first_id == 0) ? 32'd2 : 32'd0);
    ack_cycle();

    // New edge coinciding with the ack of the same channel
    set_mask(4'b0001);
    pulse(4'b0001);
    wait_irq("t6_irq");
    chk("t6_id", 32'(bus.irq_id), 32'd0);
    bus.irq_in[0] = 1'b1;
    tick();
    bus.irq_in[0] = 1'b0;
    tick();
    bus.ExtIAck = 1'b1;
    tick();
    chk("t6_keep", 32'(bus.pending_q), 32'h1);
    chk("t6_drop", 32'(bus.ExtIRQ),    32'd0);
    bus.ExtIAck = 1'b0;
    tick(2);
    chk("t6_again", 32'(bus.ExtIRQ), 32'd1);
    chk("t6_id2",   32'(bus.irq_id), 32'd0);
    ack_cycle();
    chk("t6_clr", 32'(bus.pending_q), 32'd0);

    // Asynchronous reset in the middle of a request
    set_mask(4'b1111);
    pulse(4'b1000);
    wait_irq("t7_irq");
    #2;
    reset = 1'b0;
    #1;
    chk("t7_irq",  32'(bus.ExtIRQ),    32'd0);
    chk("t7_mask", 32'(bus.mask_q),    32'd0);
    chk("t7_pend", 32'(bus.pending_q), 32'd0);
    chk("t7_id",   32'(bus.irq_id),    32'd0);
    tick(2);
    reset = 1'b1;
    tick();

    // Randomized traffic against the model
    set_mask(4'b1111);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        bus.irq_in = bus.irq_in ^ (4'b0001 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 39) == 0) begin
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'($urandom_range(0, 15));
      end else begin
        bus.mask_we = 1'b0;
      end
      if (bus.ExtIAck) begin
        if ($urandom_range(0, 2) == 0) bus.ExtIAck = 1'b0;
      end else if (bus.ExtIRQ) begin
        if ($urandom_range(0, 2) == 0) bus.ExtIAck = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        bus.ExtIAck = 1'b1;
      end
      tick();
    end
    bus.mask_we = 1'b0;
    bus.ExtIAck = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
